// File: rtl/button_request_gen.sv
`default_nettype none
// ============================================================================
//  Module      : button_request_gen
//  Description : Debounces a raw asynchronous push-button and turns each
//                accepted press into a one-cycle request for the lamp timer.
//                Presses accepted while the lamp is lit are dropped and
//                counted instead. Also provides a held level, a one-shot
//                long-press pulse and saturating accepted/dropped counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_request_gen #(
    parameter int DB_CYCLES   = 4,   // consecutive synchronized samples (2..255)
    parameter int LONG_CYCLES = 16,  // edges after accept before long_press (1..65535)
    parameter int CNT_W       = 8    // width of the status counters
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             lamp_on,
    output logic             req,
    output logic             held,
    output logic             long_press,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] drop_count
);

    // Debounce state encoding
    localparam logic [1:0] c_released   = 2'd0;
    localparam logic [1:0] c_press_db   = 2'd1;
    localparam logic [1:0] c_pressed    = 2'd2;
    localparam logic [1:0] c_release_db = 2'd3;

    // Terminal counts; db_cnt counts the samples already seen, so the
    // DB_CYCLES-th sample is the one that finds db_cnt at DB_CYCLES-1.
    localparam logic [7:0]       c_db_last   = 8'(DB_CYCLES - 1);
    localparam logic [15:0]      c_long_last = 16'(LONG_CYCLES - 1);
    localparam logic [15:0]      c_long_max  = 16'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    logic             r_sync1;
    logic             r_btn_s;
    logic [1:0]       r_state;
    logic [7:0]       r_db_cnt;
    logic [15:0]      r_hold_cnt;
    logic             r_req;
    logic             r_held;
    logic             r_long;
    logic [CNT_W-1:0] r_req_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [1:0]       w_state_nxt;
    logic [7:0]       w_db_nxt;
    logic             w_accept;
    logic             w_release;
    logic             w_holding;

    // Two-flop synchronizer; only r_btn_s is seen by the debouncer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_btn_s <= r_sync1;
        end
    end

    // Debounce next-state logic; flags the accept and final-release edges
    always_comb begin
        w_state_nxt = r_state;
        w_db_nxt    = r_db_cnt;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            c_released: begin
                if (r_btn_s) begin
                    w_state_nxt = c_press_db;
                    w_db_nxt    = 8'd1;
                end else begin
                    w_db_nxt    = 8'd0;
                end
            end
            c_press_db: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_released;
                    w_db_nxt    = 8'd0;
                end else if (r_db_cnt == c_db_last) begin
                    w_state_nxt = c_pressed;
                    w_db_nxt    = 8'd0;
                    w_accept    = 1'b1;
                end else begin
                    w_db_nxt    = r_db_cnt + 8'd1;
                end
            end
            c_pressed: begin
                if (!r_btn_s) begin
                    w_state_nxt = c_release_db;
                    w_db_nxt    = 8'd1;
                end
            end
            c_release_db: begin
                // A bounce back to 1 resumes the same press: no new request
                if (r_btn_s) begin
                    w_state_nxt = c_pressed;
                end else if (r_db_cnt == c_db_last) begin
                    w_state_nxt = c_released;
                    w_db_nxt    = 8'd0;
                    w_release   = 1'b1;
                end else begin
                    w_db_nxt    = r_db_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_released;
                w_db_nxt    = 8'd0;
            end
        endcase
    end

    assign w_holding = (r_state == c_pressed) || (r_state == c_release_db);

    // Debounce state and sample counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_released;
            r_db_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_nxt;
        end
    end

    // Request pulse: lamp_on is consulted only at the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= 1'b0;
        end else begin
            r_req <= w_accept && !lamp_on;
        end
    end

    // Held level spans PRESSED and RELEASE_DB, independent of lamp_on
    always_ff @(posedge clk) begin
        if (reset) begin
            r_held <= 1'b0;
        end else if (w_accept) begin
            r_held <= 1'b1;
        end else if (w_release) begin
            r_held <= 1'b0;
        end
    end

    // Hold duration counter; saturation at LONG_CYCLES makes long_press one-shot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= 16'd0;
            r_long     <= 1'b0;
        end else begin
            r_long <= w_holding && (r_hold_cnt == c_long_last);
            if (w_accept) begin
                r_hold_cnt <= 16'd0;
            end else if (w_holding && (r_hold_cnt != c_long_max)) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end
        end
    end

    // Saturating accepted/dropped press counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (w_accept) begin
            if (!lamp_on) begin
                if (r_req_cnt != c_cnt_max) begin
                    r_req_cnt <= r_req_cnt + 1'b1;
                end
            end else begin
                if (r_drop_cnt != c_cnt_max) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    assign req        = r_req;
    assign held       = r_held;
    assign long_press = r_long;
    assign req_count  = r_req_cnt;
    assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/button_request_gen.md
Name: button_request_gen

Overview:
- Producer side of the lamp-timer request line.
- Conditions a raw, bouncy, asynchronous push-button and emits one clean single-cycle request pulse per debounced press, to drive the timer controller's `b` input.
- Takes the timer's lamp output back as `lamp_on`. Presses accepted while the lamp is lit are dropped and counted, not forwarded.
- Also reports a held level, a one-shot long-press pulse, and saturating accepted/dropped press counters for status registers.

Parameters:
- DB_CYCLES, 4, consecutive synchronized samples needed to accept a press or a release (legal range 2..255).
- LONG_CYCLES, 16, cycles after press acceptance before long_press fires (legal range 1..65535).
- CNT_W, 8, width of req_count and drop_count.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  1  raw push-button level, asynchronous, may bounce.
- lamp_on  input  1  timer lamp state (timer output x); 1 = illuminating/busy.
- req  output  1  one-cycle press request to the timer `b` input; registered.
- held  output  1  1 while the debounced button is considered pressed; registered.
- long_press  output  1  one-cycle pulse, at most once per press; registered.
- req_count  output  CNT_W  accepted presses, saturating.
- drop_count  output  CNT_W  presses dropped because lamp_on=1, saturating.

Behaviour:
- Interface decided: one clock, `clk`; reset is synchronous and active-high, `reset`.
- Reset: while reset=1 at an edge, the following are all cleared to 0 and state goes to RELEASED:
  - outputs req, held, long_press, req_count, drop_count;
  - both synchronizer flops;
  - db_cnt and hold_cnt.
- Reset has priority over every other event and may occur mid-press. A button still held after reset deasserts is detected as a new press with full latency.
- Synchronizer: two flops, sync1<=btn_raw, btn_s<=sync1. The FSM uses btn_s only.
- FSM states: RELEASED, PRESS_DB, PRESSED, RELEASE_DB.
  - RELEASED: btn_s=1 -> PRESS_DB, db_cnt<=1. Else stay, db_cnt<=0.
  - PRESS_DB: btn_s=0 -> RELEASED, db_cnt<=0 (no event). btn_s=1 and db_cnt==DB_CYCLES-1 -> PRESSED (accept edge). Else db_cnt++.
  - PRESSED: btn_s=0 -> RELEASE_DB, db_cnt<=1. Else stay.
  - RELEASE_DB: btn_s=1 -> PRESSED, no new request. btn_s=0 and db_cnt==DB_CYCLES-1 -> RELEASED. Else db_cnt++.
- Accept edge, lamp_on=0: req<=1 for exactly one cycle; req_count++.
- Accept edge, lamp_on=1: req stays 0; drop_count++.
- Counters saturate at all-ones and never wrap.
- req is 0 in every cycle other than the one following an accept edge. Back-to-back requests are impossible (minimum 2*DB_CYCLES cycles apart).
- Latency: if btn_raw is first 1 at edge t0 and stays stable, req is high from edge t0+DB_CYCLES+1 to t0+DB_CYCLES+2.
- held:
  - Becomes 1 at the accept edge, regardless of lamp_on.
  - Stays 1 through PRESSED and RELEASE_DB.
  - Falls at the edge entering RELEASED; with raw 0 from edge r0, that is r0+DB_CYCLES+1.
- hold_cnt: cleared to 0 at the accept edge, increments each edge in PRESSED or RELEASE_DB, saturates at LONG_CYCLES. Release bounces do not clear it.
- long_press: pulses 1 for one cycle at the edge where hold_cnt goes LONG_CYCLES-1 -> LONG_CYCLES, i.e. LONG_CYCLES edges after req rises. It fires even if the press was dropped. There is no second pulse until a new accept.
- The lamp_on value is used only at the accept edge. Later changes have no effect on the current press.

Test Plan:
- Reset with btn_raw=1 held: req, held, long_press, req_count and drop_count are all 0 during reset. After reset deasserts at edge t0, req pulses at t0+5 (DB_CYCLES=4) and req_count=1.
- Clean press, DB_CYCLES=4, lamp_on=0: btn_raw 1 from t0 for 12 cycles, then 0 at r0. Expected:
  - req=1 only in cycle t0+5;
  - held rises at t0+5 and falls at r0+5;
  - req_count=1, drop_count=0.
- Bounce: btn_raw pattern 1,1,1,0,1,1,0,1,1,1,1 then steady. Expected:
  - exactly one req, at the 4th consecutive synchronized 1;
  - release bounce 0,0,1,0,0,0,0 produces no extra req and held stays 1 until the 4 consecutive 0s.
- Busy drop: lamp_on=1 at the accept edge. Expected: req stays 0, held=1, drop_count=1, req_count unchanged. A second press with lamp_on=0 gives req pulse and req_count=1.
- Long press, LONG_CYCLES=16: hold 40 cycles. Expected: long_press single pulse exactly 16 edges after req rises, none later. Release, then a 5-cycle press gives no long_press.
- Saturation, CNT_W=2: 5 accepted presses give req_count=3 (no wrap). Reset mid-hold clears req_count to 0, held to 0 and state to RELEASED.
